rcl_multi_circle: RTL and testbench

//   Line/circle relation classifier, parametrised successor of the single-circle checker.

---
 rtl/rcl_multi_circle.sv | 208 ++++++++++++++++++++
 tb/tb_rcl_multi_circle.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rcl_multi_circle.sv
// Line/circle relation classifier: one line and NUM_CIRC circles per burst, division-free s^2 vs k*d compare.
// Optional macro RCL_DEGEN_EN: a==0 && b==0 reports code 3 for every circle in the burst.
module rcl_multi_circle #(
   parameter int W        = 5,
   parameter int NUM_CIRC = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] coef_L,
   input  logic [W-1:0] coef_Q,
   output logic         busy,
   output logic         out_valid,
   output logic [1:0]   out
);

   localparam int SW = 2*W + 2;
   localparam int NW = 4*W + 4;
   localparam int RW = 3*W;
   localparam logic [3:0] LAST = 4'(NUM_CIRC - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

   state_t r_state, w_next;

   logic [1:0]            r_ph;
   logic [3:0]            r_circ;
   logic [3:0]            r_cnt;
   logic [W-1:0]          r_a, r_b, r_c, r_m, r_n;
   logic                  r_s1Valid, r_s2Valid;
   logic signed [SW-1:0]  r_s;
   logic [2*W-1:0]        r_d;
   logic [W-1:0]          r_k;
   logic [3:0]            r_s1Idx, r_s2Idx;
   logic [NW-1:0]         r_num;
   logic [RW-1:0]         r_rhs;
   logic [2*NUM_CIRC-1:0] r_buf;
   logic [1:0]            r_out;
`ifdef RCL_DEGEN_EN
   logic                  r_s1Degen, r_s2Degen;
`endif

   logic                  w_take, w_lastCap;
   logic [W-1:0]          w_c;
   logic signed [SW-1:0]  w_aE, w_bE, w_cE, w_mE, w_nE, w_s;
   logic signed [2*W-1:0] w_aD, w_bD, w_dS;
   logic signed [NW-1:0]  w_sX, w_sq;
   logic [RW-1:0]         w_rhs;
   logic [1:0]            w_code;
   logic [3:0]            w_outIdx;

   assign w_take    = in_valid && (r_state == S_IDLE || r_state == S_LOAD);
   assign w_lastCap = w_take && (r_ph == 2'd2) && (r_circ == LAST);

   // Circle 0's k arrives together with c, so stage 1 takes c straight from the port then.
   assign w_c  = (r_circ == 4'd0) ? coef_L : r_c;
   assign w_aE = {{(SW-W){r_a[W-1]}}, r_a};
   assign w_bE = {{(SW-W){r_b[W-1]}}, r_b};
   assign w_cE = {{(SW-W){w_c[W-1]}}, w_c};
   assign w_mE = {{(SW-W){r_m[W-1]}}, r_m};
   assign w_nE = {{(SW-W){r_n[W-1]}}, r_n};
   assign w_s  = w_aE*w_mE + w_bE*w_nE + w_cE;
   assign w_aD = {{W{r_a[W-1]}}, r_a};
   assign w_bD = {{W{r_b[W-1]}}, r_b};
   assign w_dS = w_aD*w_aD + w_bD*w_bD;

   assign w_sX  = {{(NW-SW){r_s[SW-1]}}, r_s};
   assign w_sq  = w_sX * w_sX;
   assign w_rhs = {{(RW-W){1'b0}}, r_k} * {{(RW-2*W){1'b0}}, r_d};

   assign w_outIdx = r_cnt + 4'd1;

   always_comb begin
      w_code = 2'd2;
      if (r_num > {{(NW-RW){1'b0}}, r_rhs})
         w_code = 2'd0;
      else if (r_num == {{(NW-RW){1'b0}}, r_rhs})
         w_code = 2'd1;
`ifdef RCL_DEGEN_EN
      if (r_s2Degen)
         w_code = 2'd3;
`endif
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (in_valid) w_next = S_LOAD;
         S_LOAD: begin
            if (!in_valid)
               w_next = S_IDLE;
            else if (w_lastCap)
               w_next = S_CALC;
         end
         S_CALC: if (r_cnt == 4'd2) w_next = S_OUT;
         S_OUT:  if (r_cnt == LAST) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ph   <= '0;
         r_circ <= '0;
         r_cnt  <= '0;
         r_out  <= '0;
      end else begin
         if (w_take) begin
            if (r_ph == 2'd2) begin
               r_ph   <= '0;
               r_circ <= r_circ + 4'd1;
            end else begin
               r_ph <= r_ph + 2'd1;
            end
         end else begin
            r_ph   <= '0;
            r_circ <= '0;
         end
         if (r_state == S_CALC)
            r_cnt <= (r_cnt == 4'd2) ? 4'd0 : r_cnt + 4'd1;
         else if (r_state == S_OUT)
            r_cnt <= r_cnt + 4'd1;
         else
            r_cnt <= '0;
         // Results replay from the buffer one slot ahead, so out lines up with out_valid.
         if (r_state == S_CALC && r_cnt == 4'd2)
            r_out <= r_buf[1:0];
         else if (r_state == S_OUT && r_cnt != LAST)
            r_out <= r_buf[{w_outIdx, 1'b0} +: 2];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= '0;
         r_b <= '0;
         r_c <= '0;
         r_m <= '0;
         r_n <= '0;
      end else if (w_take) begin
         case (r_ph)
            2'd0: begin
               r_m <= coef_Q;
               if (r_circ == 4'd0) r_a <= coef_L;
            end
            2'd1: begin
               r_n <= coef_Q;
               if (r_circ == 4'd0) r_b <= coef_L;
            end
            default: if (r_circ == 4'd0) r_c <= coef_L;
         endcase
      end
   end

   // Three-stage compare pipeline: products, squares, then the buffered verdict.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Valid <= 1'b0;
         r_s2Valid <= 1'b0;
         r_s       <= '0;
         r_d       <= '0;
         r_k       <= '0;
         r_s1Idx   <= '0;
         r_s2Idx   <= '0;
         r_num     <= '0;
         r_rhs     <= '0;
         r_buf     <= '0;
`ifdef RCL_DEGEN_EN
         r_s1Degen <= 1'b0;
         r_s2Degen <= 1'b0;
`endif
      end else begin
         r_s1Valid <= w_take && (r_ph == 2'd2);
         if (w_take && r_ph == 2'd2) begin
            r_s     <= w_s;
            r_d     <= $unsigned(w_dS);
            r_k     <= coef_Q;
            r_s1Idx <= r_circ;
`ifdef RCL_DEGEN_EN
            r_s1Degen <= (r_a == '0) && (r_b == '0);
`endif
         end
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_num   <= $unsigned(w_sq);
            r_rhs   <= w_rhs;
            r_s2Idx <= r_s1Idx;
`ifdef RCL_DEGEN_EN
            r_s2Degen <= r_s1Degen;
`endif
         end
         if (r_s2Valid)
            r_buf[{r_s2Idx, 1'b0} +: 2] <= w_code;
      end
   end

   assign busy      = (r_state != S_IDLE) || in_valid;
   assign out_valid = (r_state == S_OUT);
   assign out       = r_out;

endmodule

// File: tb/tb_rcl_multi_circle.sv
// Self-checking bench for rcl_multi_circle: directed and random bursts against an arithmetic reference.
module tb_rcl_multi_circle;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       inValid;
   logic [4:0] coefL, coefQ;
   bit         sel;

   logic       busy0, ov0, busy1, ov1;
   logic [1:0] out0, out1;
   logic       busyS, ovS;
   logic [1:0] outS;

   rcl_multi_circle #(.W(5), .NUM_CIRC(2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid & ~sel), .coef_L(coefL), .coef_Q(coefQ),
      .busy(busy0), .out_valid(ov0), .out(out0)
   );

   rcl_multi_circle #(.W(5), .NUM_CIRC(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(inValid & sel), .coef_L(coefL), .coef_Q(coefQ),
      .busy(busy1), .out_valid(ov1), .out(out1)
   );

   assign busyS = sel ? busy1 : busy0;
   assign ovS   = sel ? ov1 : ov0;
   assign outS  = sel ? out1 : out0;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nAssert = 0;
   int nFail   = 0;
   int lineC[3];
   int cm[16], cn[16], ck[16];
   int lastCyc;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "[TB] watchdog");
   end

   // Geometry reference: compare squared distance against radius^2 using exact integers.
   function automatic logic [1:0] refCode(input int a, b, c, m, n, k);
      longint s, num, rhs;
`ifdef RCL_DEGEN_EN
      if (a == 0 && b == 0) return 2'd3;
`endif
      s   = longint'(a)*m + longint'(b)*n + c;
      num = s*s;
      rhs = longint'(k) * (longint'(a)*a + longint'(b)*b);
      if (num > rhs) return 2'd0;
      if (num == rhs) return 2'd1;
      return 2'd2;
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nAssert++;
      assert (obs === expv) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic setLine(input int a, b, c);
      lineC[0] = a; lineC[1] = b; lineC[2] = c;
   endtask

   task automatic setCircle(input int i, m, n, k);
      cm[i] = m; cn[i] = n; ck[i] = k;
   endtask

   task automatic randomBurst(input int nCirc);
      setLine($urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16);
      for (int i = 0; i < nCirc; i++)
         setCircle(i, $urandom_range(0, 31) - 16, $urandom_range(0, 31) - 16, $urandom_range(0, 31));
   endtask

   task automatic applyStimulus(input int nCirc, input int len, input bit startNow);
      for (int t = 0; t < len; t++) begin
         if (!(t == 0 && startNow)) begin
            @(posedge clk); #1;
         end
         inValid = 1'b1;
         coefL   = (t < 3) ? 5'(lineC[t]) : 5'($urandom);
         case (t % 3)
            0:       coefQ = 5'(cm[t/3]);
            1:       coefQ = 5'(cn[t/3]);
            default: coefQ = 5'(ck[t/3]);
         endcase
         lastCyc = cyc;
      end
      @(posedge clk); #1;
      inValid = 1'b0;
      coefL   = 5'($urandom);
      coefQ   = 5'($urandom);
      if (len < 3*nCirc) lastCyc = -1;
   endtask

   task automatic checkOutput(input int nCirc);
      int waited = 0;
      logic [1:0] expv [16];
      for (int i = 0; i < nCirc; i++)
         expv[i] = refCode(lineC[0], lineC[1], lineC[2], cm[i], cn[i], ck[i]);
      while (ovS !== 1'b1 && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      checkVal("latency", cyc, lastCyc + 4);
      for (int j = 0; j < nCirc; j++) begin
         checkVal("out_valid", ovS, 1);
         checkVal($sformatf("out[%0d]", j), outS, expv[j]);
         checkVal("busy_out", busyS, 1);
         if (j < nCirc - 1) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      checkVal("out_valid_end", ovS, 0);
      checkVal("busy_end", busyS, 0);
      checkVal("out_hold", outS, expv[nCirc-1]);
   endtask

   initial begin
      rst_n   = 1'b0;
      inValid = 1'b0;
      coefL   = '0;
      coefQ   = '0;
      sel     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkVal("rst_busy", busy0, 0);
      checkVal("rst_out_valid", ov0, 0);
      checkVal("rst_out", out0, 0);
      rst_n = 1'b1;

      $display("[TB] miss then tangent");
      setLine(1, 0, 0); setCircle(0, 3, 0, 4); setCircle(1, 2, 0, 4);
      applyStimulus(2, 6, 1'b0);
      checkOutput(2);

      $display("[TB] cut then miss, back-to-back");
      setCircle(0, 1, 0, 4); setCircle(1, 3, 0, 4);
      applyStimulus(2, 6, 1'b1);
      checkOutput(2);

      $display("[TB] extreme coefficients");
      setLine(-16, -16, -16); setCircle(0, -16, -16, 31); setCircle(1, 15, 15, 31);
      applyStimulus(2, 6, 1'b0);
      checkOutput(2);

      $display("[TB] degenerate lines");
      setLine(0, 0, 0); setCircle(0, 5, -3, 7); setCircle(1, -2, 9, 0);
      applyStimulus(2, 6, 1'b0);
      checkOutput(2);
      setLine(0, 0, 1);
      applyStimulus(2, 6, 1'b0);
      checkOutput(2);

      $display("[TB] aborted burst");
      randomBurst(2);
      applyStimulus(2, 4, 1'b0);
      @(posedge clk); #1;
      checkVal("abort_busy", busyS, 0);
      for (int i = 0; i < 8; i++) begin
         checkVal("abort_no_out", ovS, 0);
         @(posedge clk); #1;
      end
      setLine(2, -3, 1); setCircle(0, 4, 3, 2); setCircle(1, -1, 2, 13);
      applyStimulus(2, 6, 1'b0);
      checkOutput(2);

      $display("[TB] random bursts");
      for (int r = 0; r < 12; r++) begin
         randomBurst(2);
         applyStimulus(2, 6, (r % 2) == 1);
         checkOutput(2);
      end

      $display("[TB] reset during output");
      randomBurst(2);
      applyStimulus(2, 6, 1'b0);
      for (int i = 0; i < 20 && ovS !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      checkVal("pre_reset_out_valid", ovS, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkVal("reset_out_valid", ovS, 0);
      checkVal("reset_out", outS, 0);
      checkVal("reset_busy", busyS, 0);
      @(posedge clk); #1;
      checkVal("reset_hold_out_valid", ovS, 0);
      rst_n = 1'b1;

      $display("[TB] single-circle bursts back-to-back");
      sel = 1'b1;
      setLine(1, 0, 0); setCircle(0, 2, 0, 4);
      applyStimulus(1, 3, 1'b0);
      checkOutput(1);
      for (int r = 0; r < 4; r++) begin
         randomBurst(1);
         applyStimulus(1, 3, 1'b1);
         checkOutput(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
